// File: rtl/if_fetch_if.sv
// ----------------------------------------------------------------------------
// if_fetch_if -- bus between the instruction-fetch stage and its neighbours.
//
// Groups the instruction-memory port, the hazard/redirect controls and the
// IF/ID register outputs of if_fetch into one bundle.
//
//   iaddr      fetch -> imem     word address (the PC register)
//   idata      imem  -> fetch    instruction word, combinational read of iaddr
//   stall      hazard -> fetch   hold PC and IF/ID for this edge
//   br_taken   EX    -> fetch    branch resolved taken, redirect to br_target
//   br_target  EX    -> fetch    branch target address
//   jump       ID    -> fetch    J-type instruction sitting in IF/ID
//   id_instr   fetch -> ID       IF/ID instruction register
//   id_pc4     fetch -> ID       IF/ID PC+4 register
//   id_valid   fetch -> ID       IF/ID holds a real instruction (not a bubble)
//   op, func   fetch -> decoder  id_instr[31:26] and id_instr[5:0]
//   fetch_cnt  fetch -> any      number of instructions loaded into IF/ID
//
// The slave modport belongs to the fetch stage; the master modport belongs
// to whatever surrounds it (memory, hazard unit, EX/ID, or a testbench).
// ----------------------------------------------------------------------------
interface if_fetch_if;

    logic [31:0] iaddr;
    logic [31:0] idata;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [31:0] fetch_cnt;

    modport master (
        input  iaddr,
        output idata,
        output stall,
        output br_taken,
        output br_target,
        output jump,
        input  id_instr,
        input  id_pc4,
        input  id_valid,
        input  op,
        input  func,
        input  fetch_cnt
    );

    modport slave (
        output iaddr,
        input  idata,
        input  stall,
        input  br_taken,
        input  br_target,
        input  jump,
        output id_instr,
        output id_pc4,
        output id_valid,
        output op,
        output func,
        output fetch_cnt
    );

endinterface

// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch -- instruction-fetch stage of a 5-stage pipeline.
//
// Holds the PC and the IF/ID pipeline register. Each rising edge performs
// exactly one action, chosen by priority:
//   branch taken (EX) > jump (ID, only if IF/ID is valid) > stall > fetch
// Branch and jump both redirect the PC and flush IF/ID to a bubble; a stall
// freezes everything; a normal fetch latches idata and advances the PC by 4.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset, overrides every other input
//   bus    if_fetch_if.slave -- memory port, hazard/redirect inputs and
//          IF/ID outputs (see if_fetch_if.sv)
// Parameters:
//   RESET_PC  PC loaded on reset (low two bits are forced to zero)
// ----------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    if_fetch_if.slave  bus
);

    // Word alignment mask; applied to every value that can land in the PC.
    localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_AL = RESET_PC & ALIGN_MASK;

    typedef enum logic [1:0] {
        ACT_FETCH,
        ACT_HOLD,
        ACT_BRANCH,
        ACT_JUMP
    } act_e;

    // Architectural state.
    logic [31:0] r_pc;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc4;
    logic        r_id_valid;
    logic [31:0] r_fetch_cnt;

    // Per-edge decision and the candidate next-PC values.
    act_e        w_act;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_pc;
    logic [31:0] w_jump_pc;

    // 32-bit modulo add: 0xFFFF_FFFC + 4 wraps to 0 with no extra logic.
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_pc    = bus.br_target & ALIGN_MASK;
    // J-type target: upper nibble of the jump's own PC+4, 26-bit word index.
    assign w_jump_pc  = {r_id_pc4[31:28], r_id_instr[25:0], 2'b00};

    // Action select. A bubble in IF/ID carries no real jump, so jump only
    // counts when id_valid is set; otherwise stall/fetch decide.
    // NOTE: w_act gets its default before any branch, so every path assigns
    // it and no latch is inferred.
    always_comb begin
        w_act = ACT_FETCH;
        if (bus.br_taken) begin
            w_act = ACT_BRANCH;
        end else if (bus.jump && r_id_valid) begin
            w_act = ACT_JUMP;
        end else if (bus.stall) begin
            w_act = ACT_HOLD;
        end
    end

    // PC and IF/ID register. Reset is sampled on the clock edge only.
    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values of the others, exactly like the hardware.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC_AL;
            r_id_instr  <= 32'd0;
            r_id_pc4    <= 32'd0;
            r_id_valid  <= 1'b0;
            r_fetch_cnt <= 32'd0;
        end else begin
            unique case (w_act)
                ACT_FETCH: begin
                    r_pc        <= w_pc_plus4;
                    r_id_instr  <= bus.idata;
                    r_id_pc4    <= w_pc_plus4;
                    r_id_valid  <= 1'b1;
                    r_fetch_cnt <= r_fetch_cnt + 32'd1;
                end
                ACT_HOLD: begin
                    r_pc        <= r_pc;
                    r_id_instr  <= r_id_instr;
                    r_id_pc4    <= r_id_pc4;
                    r_id_valid  <= r_id_valid;
                    r_fetch_cnt <= r_fetch_cnt;
                end
                ACT_BRANCH: begin
                    // Redirect and discard whatever sat in IF/ID, including a
                    // stalled instruction.
                    r_pc        <= w_br_pc;
                    r_id_instr  <= 32'd0;
                    r_id_pc4    <= 32'd0;
                    r_id_valid  <= 1'b0;
                    r_fetch_cnt <= r_fetch_cnt;
                end
                ACT_JUMP: begin
                    r_pc        <= w_jump_pc;
                    r_id_instr  <= 32'd0;
                    r_id_pc4    <= 32'd0;
                    r_id_valid  <= 1'b0;
                    r_fetch_cnt <= r_fetch_cnt;
                end
                default: begin
                    r_pc        <= r_pc;
                    r_id_instr  <= r_id_instr;
                    r_id_pc4    <= r_id_pc4;
                    r_id_valid  <= r_id_valid;
                    r_fetch_cnt <= r_fetch_cnt;
                end
            endcase
        end
    end

    // Outputs are straight from registers.
    assign bus.iaddr     = r_pc;
    assign bus.id_instr  = r_id_instr;
    assign bus.id_pc4    = r_id_pc4;
    assign bus.id_valid  = r_id_valid;
    assign bus.op        = r_id_instr[31:26];
    assign bus.func      = r_id_instr[5:0];
    assign bus.fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_if_fetch.sv
// ----------------------------------------------------------------------------
// tb_if_fetch -- self-checking bench for if_fetch.
//
// A reference model of the fetch stage's architectural state is advanced on
// every rising edge from the inputs; a compare process checks all DUT outputs
// against it on every falling edge once reset has been applied. Directed
// scenarios add literal expectations at the points of interest, then a
// pseudo-random phase exercises mixed branch/jump/stall/reset traffic.
// ----------------------------------------------------------------------------
module tb_if_fetch;

    logic clk;
    logic rst_n;

    if_fetch_if bus ();

    if_fetch #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Instruction memory: mode 0 returns 0x20 everywhere except one
    // programmable word; mode 1 returns an address-dependent pattern.
    // ------------------------------------------------------------------
    int unsigned mem_mode;
    logic [31:0] special_addr;
    logic [31:0] special_data;

    function automatic logic [31:0] mem_word(input logic [31:0] addr,
                                             input int unsigned mode,
                                             input logic [31:0] sa,
                                             input logic [31:0] sd);
        if (addr == sa) return sd;
        if (mode == 0) return 32'h0000_0020;
        return {addr[7:2], addr[31:6]} ^ 32'h5A5A_0F0F;
    endfunction

    assign bus.idata = mem_word(bus.iaddr, mem_mode, special_addr, special_data);

    // ------------------------------------------------------------------
    // Counters and check task.
    // ------------------------------------------------------------------
    int n_cmp;
    int n_err;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the architectural state after each edge.
    // ------------------------------------------------------------------
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_cnt;
    bit          m_ok;

    initial m_ok = 1'b0;

    always @(posedge clk) begin : model
        logic [31:0] word;
        if (!rst_n) begin
            m_pc    = 32'h0;
            m_instr = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
            m_cnt   = 32'h0;
            m_ok    = 1'b1;
        end else if (bus.br_taken) begin
            m_pc    = {bus.br_target[31:2], 2'b00};
            m_instr = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
        end else if (bus.jump && m_valid) begin
            m_pc    = {m_pc4[31:28], m_instr[25:0], 2'b00};
            m_instr = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
        end else if (!bus.stall) begin
            word    = mem_word(m_pc, mem_mode, special_addr, special_data);
            m_pc    = m_pc + 32'd4;
            m_instr = word;
            m_pc4   = m_pc;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 32'd1;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("iaddr",     bus.iaddr,            m_pc);
            check("id_instr",  bus.id_instr,         m_instr);
            check("id_pc4",    bus.id_pc4,           m_pc4);
            check("id_valid",  {31'd0, bus.id_valid}, {31'd0, m_valid});
            check("op",        {26'd0, bus.op},      {26'd0, m_instr[31:26]});
            check("func",      {26'd0, bus.func},    {26'd0, m_instr[5:0]});
            check("fetch_cnt", bus.fetch_cnt,        m_cnt);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus.
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall     = 1'b0;
        bus.br_taken  = 1'b0;
        bus.br_target = 32'h0;
        bus.jump      = 1'b0;
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        mem_mode     = 0;
        special_addr = 32'hDEAD_BEE0;
        special_data = 32'h0000_0020;
        rst_n        = 1'b0;
        idle_inputs();

        // Reset with garbage on the control inputs.
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h1234_5678;
        bus.jump      = 1'b1;
        bus.stall     = 1'b1;
        cyc();
        cyc();
        check("rst iaddr",     bus.iaddr, 32'h0);
        check("rst id_valid",  {31'd0, bus.id_valid}, 32'd0);
        check("rst fetch_cnt", bus.fetch_cnt, 32'd0);
        check("rst op",        {26'd0, bus.op}, 32'd0);
        check("rst func",      {26'd0, bus.func}, 32'd0);
        idle_inputs();

        // Free-running fetch of 0x20 words.
        rst_n = 1'b1;
        cyc();
        check("run1 iaddr", bus.iaddr, 32'h4);
        cyc();
        check("run2 iaddr",  bus.iaddr,  32'h8);
        check("run2 id_pc4", bus.id_pc4, 32'h8);
        cyc();
        check("run3 iaddr",     bus.iaddr, 32'hC);
        check("run3 fetch_cnt", bus.fetch_cnt, 32'd3);
        check("run3 id_valid",  {31'd0, bus.id_valid}, 32'd1);
        check("run3 id_instr",  bus.id_instr, 32'h0000_0020);
        check("run3 func",      {26'd0, bus.func}, 32'h20);

        // Stall at PC=8 for two edges.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        check("pre-stall iaddr", bus.iaddr, 32'h8);
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("stall iaddr",     bus.iaddr, 32'h8);
            check("stall id_pc4",    bus.id_pc4, 32'h8);
            check("stall fetch_cnt", bus.fetch_cnt, 32'd2);
        end
        bus.stall = 1'b0;
        cyc();
        check("resume iaddr",     bus.iaddr, 32'hC);
        check("resume id_pc4",    bus.id_pc4, 32'hC);
        check("resume fetch_cnt", bus.fetch_cnt, 32'd3);

        // Branch to 0x1000_0000, fetch a J instruction, take the jump.
        special_addr  = 32'h1000_0000;
        special_data  = 32'h0800_0040;
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h1000_0000;
        cyc();
        check("br iaddr",     bus.iaddr, 32'h1000_0000);
        check("br id_valid",  {31'd0, bus.id_valid}, 32'd0);
        check("br id_instr",  bus.id_instr, 32'h0);
        check("br fetch_cnt", bus.fetch_cnt, 32'd3);
        idle_inputs();
        cyc();
        check("j load id_instr", bus.id_instr, 32'h0800_0040);
        check("j load id_pc4",   bus.id_pc4, 32'h1000_0004);
        check("j load op",       {26'd0, bus.op}, 32'h2);
        bus.jump = 1'b1;
        cyc();
        check("jump iaddr",     bus.iaddr, 32'h1000_0100);
        check("jump id_valid",  {31'd0, bus.id_valid}, 32'd0);
        check("jump id_instr",  bus.id_instr, 32'h0);
        check("jump fetch_cnt", bus.fetch_cnt, 32'd4);

        // Jump held high over the bubble: must fetch, not redirect.
        cyc();
        check("bubble jump iaddr",     bus.iaddr, 32'h1000_0104);
        check("bubble jump id_valid",  {31'd0, bus.id_valid}, 32'd1);
        check("bubble jump fetch_cnt", bus.fetch_cnt, 32'd5);

        // Branch + jump + stall in one edge: branch wins, IF/ID flushed.
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h0000_0203;
        bus.jump      = 1'b1;
        bus.stall     = 1'b1;
        cyc();
        check("prio iaddr",     bus.iaddr, 32'h0000_0200);
        check("prio id_valid",  {31'd0, bus.id_valid}, 32'd0);
        check("prio id_pc4",    bus.id_pc4, 32'h0);
        check("prio fetch_cnt", bus.fetch_cnt, 32'd5);
        idle_inputs();

        // PC wrap at the top of the address space.
        bus.br_taken  = 1'b1;
        bus.br_target = 32'hFFFF_FFFF;
        cyc();
        check("wrap br iaddr", bus.iaddr, 32'hFFFF_FFFC);
        idle_inputs();
        cyc();
        check("wrap iaddr",     bus.iaddr, 32'h0);
        check("wrap id_pc4",    bus.id_pc4, 32'h0);
        check("wrap id_valid",  {31'd0, bus.id_valid}, 32'd1);
        check("wrap fetch_cnt", bus.fetch_cnt, 32'd6);

        // Reset in the middle of a stall at PC=0x40.
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h0000_0040;
        cyc();
        idle_inputs();
        bus.stall = 1'b1;
        cyc();
        check("pre-rst iaddr", bus.iaddr, 32'h40);
        rst_n = 1'b0;
        cyc();
        check("mid-stall rst iaddr",     bus.iaddr, 32'h0);
        check("mid-stall rst id_valid",  {31'd0, bus.id_valid}, 32'd0);
        check("mid-stall rst fetch_cnt", bus.fetch_cnt, 32'd0);
        rst_n     = 1'b1;
        bus.stall = 1'b0;
        cyc();
        check("post-rst iaddr",  bus.iaddr, 32'h4);
        check("post-rst id_pc4", bus.id_pc4, 32'h4);

        // Mixed traffic against the model.
        mem_mode     = 1;
        special_addr = 32'hDEAD_BEE0;
        for (int i = 0; i < 400; i++) begin
            rst_n         = ($urandom_range(0, 99) != 0);
            bus.br_taken  = ($urandom_range(0, 9) == 0);
            bus.br_target = $urandom;
            bus.jump      = ($urandom_range(0, 3) == 0);
            bus.stall     = ($urandom_range(0, 4) == 0);
            cyc();
        end
        idle_inputs();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: clk  in  1  rising-edge clock; the only clock.
REQ-003 Port: rst_n  in  1  synchronous, active-low reset.
REQ-004 Port: iaddr  out  32  instruction-memory word address, equal to the PC register.
REQ-005 Port: idata  in  32  instruction word; a combinational read of iaddr, valid in the same cycle.
REQ-006 Port: stall  in  1  load-use hazard hold request from the hazard unit.
REQ-007 Port: br_taken  in  1  branch resolved taken in EX.
REQ-008 Port: br_target  in  32  branch target address from EX.
REQ-009 Port: jump  in  1  Jump control from the ID-stage decoder.
REQ-010 Port: id_instr  out  32  IF/ID instruction register.
REQ-011 Port: id_pc4  out  32  IF/ID PC+4 register.
REQ-012 Port: id_valid  out  1  IF/ID holds a real, non-bubble instruction.
REQ-013 Port: op  out  6  id_instr[31:26], driven to the decoder.
REQ-014 Port: func  out  6  id_instr[5:0], driven to the decoder.
REQ-015 Port: fetch_cnt  out  32  count of instructions loaded into IF/ID.

Function
REQ-016 PC and IF/ID update only on the rising edge of clk; op, func and iaddr are combinational from registers.
REQ-017 Per-edge priority when rst_n=1: br_taken > jump > stall > normal fetch.
REQ-018 Normal fetch:
  - PC <= PC+4.
  - id_instr <= idata.
  - id_pc4 <= PC+4.
  - id_valid <= 1.
  - fetch_cnt increments by 1.
REQ-019 Stall (no br_taken, no jump): PC, id_instr, id_pc4, id_valid and fetch_cnt all hold.
REQ-020 br_taken:
  - PC <= {br_target[31:2], 2'b00}.
  - IF/ID flushed: id_instr <= 0 (nop), id_pc4 <= 0, id_valid <= 0.
  - fetch_cnt holds.
REQ-021 jump (no br_taken):
  - PC <= {id_pc4[31:28], id_instr[25:0], 2'b00}, computed from the current IF/ID contents.
  - IF/ID flushed as in REQ-020.
  - fetch_cnt holds.
REQ-022 jump is ignored when id_valid=0, so a bubble can never redirect the PC; the stall/normal rules then apply.
REQ-023 The flush in REQ-020/REQ-021 overrides a simultaneous stall; the stalled instruction is discarded.
REQ-024 PC arithmetic is 32-bit modulo: PC 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000; id_pc4 wraps the same way.
REQ-025 fetch_cnt wraps from 32'hFFFF_FFFF to 0.
REQ-026 PC[1:0] is always 2'b00.
REQ-027 Branch latency:
  - The target instruction appears in IF/ID two edges after br_taken is sampled: redirect edge, then fetch edge.
  - One bubble follows a jump; two follow a branch, the second flushed by the EX-stage source.

Reset
REQ-028 On a clk edge with rst_n=0, regardless of all other inputs:
  - PC <= RESET_PC.
  - id_instr <= 0, id_pc4 <= 0, id_valid <= 0.
  - fetch_cnt <= 0.
REQ-029 A reset asserted mid-stall or mid-redirect discards all pending state; the first fetch after release is from RESET_PC.
REQ-030 While rst_n=0: op=0, func=0, iaddr=RESET_PC after the first edge.

Verification
REQ-031 Reset, then 3 free-running cycles, idata = 32'h0000_0020 at every address -> iaddr 0, 4, 8, 12; id_pc4 = 8 after the 2nd fetch; fetch_cnt = 3; id_valid = 1.
REQ-032 At PC=8, assert stall for 2 cycles -> iaddr stays 8; IF/ID and fetch_cnt unchanged; fetching resumes at 8 afterwards.
REQ-033 Load id_instr = 32'h0800_0040 with id_pc4 = 32'h1000_0004, then assert jump -> PC = 32'h1000_0100; id_valid = 0; id_instr = 0; fetch_cnt unchanged.
REQ-034 Assert br_taken (br_target = 32'h0000_0203), jump and stall in the same cycle -> PC = 32'h0000_0200; IF/ID flushed.
REQ-035 Force PC = 32'hFFFF_FFFC via br_target, then one normal fetch -> iaddr = 0; id_pc4 = 0.
REQ-036 Assert rst_n=0 during an active stall with PC = 32'h40 -> on the next edge PC = RESET_PC, id_valid = 0, fetch_cnt = 0.
